// File: rtl/datasg_wr_acceptor.sv
// Write-request responder: captures one datasg word per handshake into a small FIFO
// and drains it to the SRAM write port, emitting a queue-manager descriptor per write.
module datasg_wr_acceptor #(
  parameter int sg_data_width     = 64,
  parameter int sg_address_width  = 12,
  parameter int sg_des_width      = 4,
  parameter int sg_priority_width = 3,
  parameter int fifo_depth        = 4,
  parameter int cnt_width         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         request,
  input  logic [sg_priority_width-1:0] wr_priority,
  input  logic [sg_des_width-1:0]      des_port,
  input  logic [sg_address_width-1:0]  address_write,
  input  logic [sg_data_width-1:0]     data_write,
  output logic                         transfering,
  output logic                         busy,
  input  logic                         sram_ready,
  output logic                         sram_wen,
  output logic [sg_address_width-1:0]  sram_waddr,
  output logic [sg_data_width-1:0]     sram_wdata,
  output logic                         desc_valid,
  output logic [sg_des_width-1:0]      desc_port,
  output logic [sg_priority_width-1:0] desc_priority,
  output logic [sg_address_width-1:0]  desc_addr,
  output logic [cnt_width-1:0]         wr_count
);

  localparam int PW = $clog2(fifo_depth);
  localparam int EW = sg_data_width + sg_address_width + sg_priority_width + sg_des_width;
  localparam logic [PW:0]          CNT_FULL = (PW+1)'(fifo_depth);
  localparam logic [PW:0]          CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
  localparam logic [cnt_width-1:0] WR_MAX   = {cnt_width{1'b1}};
  localparam logic [cnt_width-1:0] WR_ONE   = cnt_width'(1);

  logic [EW-1:0]                mem_q [fifo_depth];
  logic [PW-1:0]                wptr_q, rptr_q;
  logic [PW:0]                  count_q, count_d;
  logic                         transfering_q;
  logic                         sram_wen_q;
  logic [sg_address_width-1:0]  sram_waddr_q;
  logic [sg_data_width-1:0]     sram_wdata_q;
  logic [sg_des_width-1:0]      desc_port_q;
  logic [sg_priority_width-1:0] desc_priority_q;
  logic [cnt_width-1:0]         wr_count_q;

  logic                         full_s;
  logic                         push_s;
  logic                         pop_s;
  logic [EW-1:0]                head_s;

  assign full_s = (count_q == CNT_FULL);
  // A pending transfering pulse blocks capture so a held request is taken only once per handshake.
  assign push_s = request && !full_s && !transfering_q;
  assign pop_s  = (count_q != {(PW+1){1'b0}}) && sram_ready;
  assign head_s = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= {data_write, address_write, wr_priority, des_port};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q          <= {PW{1'b0}};
      rptr_q          <= {PW{1'b0}};
      count_q         <= {(PW+1){1'b0}};
      transfering_q   <= 1'b0;
      sram_wen_q      <= 1'b0;
      sram_waddr_q    <= {sg_address_width{1'b0}};
      sram_wdata_q    <= {sg_data_width{1'b0}};
      desc_port_q     <= {sg_des_width{1'b0}};
      desc_priority_q <= {sg_priority_width{1'b0}};
      wr_count_q      <= {cnt_width{1'b0}};
    end else begin
      count_q       <= count_d;
      transfering_q <= push_s;
      sram_wen_q    <= pop_s;
      if (push_s) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      // Write fields hold their last value between strobes.
      if (pop_s) begin
        rptr_q          <= rptr_q + PTR_ONE;
        sram_wdata_q    <= head_s[EW-1 -: sg_data_width];
        sram_waddr_q    <= head_s[sg_priority_width+sg_des_width +: sg_address_width];
        desc_priority_q <= head_s[sg_des_width +: sg_priority_width];
        desc_port_q     <= head_s[0 +: sg_des_width];
      end
      if (sram_wen_q && (wr_count_q != WR_MAX)) begin
        wr_count_q <= wr_count_q + WR_ONE;
      end
    end
  end

  assign transfering   = transfering_q;
  assign busy          = full_s;
  assign sram_wen      = sram_wen_q;
  assign sram_waddr    = sram_waddr_q;
  assign sram_wdata    = sram_wdata_q;
  assign desc_valid    = sram_wen_q;
  assign desc_port     = desc_port_q;
  assign desc_priority = desc_priority_q;
  assign desc_addr     = sram_waddr_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_datasg_wr_acceptor.sv
// Directed bench for datasg_wr_acceptor; a second instance with a 2-bit counter checks saturation.
module tb_datasg_wr_acceptor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        request = 1'b0;
  logic [2:0]  wr_priority = 3'd0;
  logic [3:0]  des_port = 4'd0;
  logic [11:0] address_write = 12'd0;
  logic [63:0] data_write = 64'd0;
  logic        sram_ready = 1'b0;

  logic        transfering, busy, sram_wen, desc_valid;
  logic [11:0] sram_waddr, desc_addr;
  logic [63:0] sram_wdata;
  logic [3:0]  desc_port;
  logic [2:0]  desc_priority;
  logic [15:0] wr_count;

  logic        t2, b2, w2, dv2;
  logic [11:0] wa2, da2;
  logic [63:0] wd2;
  logic [3:0]  dp2;
  logic [2:0]  dpr2;
  logic [1:0]  wc2;

  int n_checks = 0;
  int n_errors = 0;
  int n_wens   = 0;
  int n_xfers  = 0;
  logic prev_xfer = 1'b0;
  logic [82:0] exp_q[$];

  datasg_wr_acceptor dut (
    .clk(clk), .rst(rst), .request(request), .wr_priority(wr_priority),
    .des_port(des_port), .address_write(address_write), .data_write(data_write),
    .transfering(transfering), .busy(busy), .sram_ready(sram_ready),
    .sram_wen(sram_wen), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .desc_valid(desc_valid), .desc_port(desc_port), .desc_priority(desc_priority),
    .desc_addr(desc_addr), .wr_count(wr_count)
  );

  datasg_wr_acceptor #(.cnt_width(2)) dut2 (
    .clk(clk), .rst(rst), .request(request), .wr_priority(wr_priority),
    .des_port(des_port), .address_write(address_write), .data_write(data_write),
    .transfering(t2), .busy(b2), .sram_ready(sram_ready),
    .sram_wen(w2), .sram_waddr(wa2), .sram_wdata(wd2),
    .desc_valid(dv2), .desc_port(dp2), .desc_priority(dpr2),
    .desc_addr(da2), .wr_count(wc2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock; records captures and scores every SRAM write against the capture order.
  task automatic tick();
    logic [82:0] e;
    @(posedge clk);
    #1;
    if (transfering === 1'b1) begin
      chk("xfer_back_to_back", {63'd0, prev_xfer}, 64'd0);
      exp_q.push_back({wr_priority, des_port, address_write, data_write});
      n_xfers++;
    end
    prev_xfer = transfering;
    if (sram_wen === 1'b1) begin
      n_wens++;
      if (exp_q.size() == 0) begin
        chk("unexpected_wen", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wdata", sram_wdata, e[63:0]);
        chk("waddr", {52'd0, sram_waddr}, {52'd0, e[75:64]});
        chk("desc", {45'd0, desc_valid, desc_addr, desc_priority, desc_port},
                    {45'd0, 1'b1, e[75:64], e[82:80], e[79:76]});
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    request = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    n_wens = 0;
    n_xfers = 0;
    prev_xfer = 1'b0;
  endtask

  task automatic present(input logic [11:0] a, input logic [63:0] d,
                         input logic [2:0] p, input logic [3:0] port);
    address_write = a;
    data_write    = d;
    wr_priority   = p;
    des_port      = port;
    request       = 1'b1;
  endtask

  task automatic wait_xfer();
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (transfering === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("xfer_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1;
    // 1: reset state
    do_reset();
    chk("rst_outputs", {59'd0, transfering, busy, sram_wen, desc_valid, 1'b0}, 64'd0);
    chk("rst_wr_count", {48'd0, wr_count}, 64'd0);
    chk("rst_wr_count2", {62'd0, wc2}, 64'd0);

    // 2: single word, latency and descriptor fields
    sram_ready = 1'b1;
    present(12'h010, 64'hA5A5_0000_0000_0001, 3'd3, 4'd2);
    tick();
    chk("t2_xfer", {63'd0, transfering}, 64'd1);
    chk("t2_wen_early", {63'd0, sram_wen}, 64'd0);
    request = 1'b0;
    tick();
    chk("t2_wen", {63'd0, sram_wen}, 64'd1);
    chk("t2_addr", {52'd0, sram_waddr}, 64'h010);
    chk("t2_data", sram_wdata, 64'hA5A5_0000_0000_0001);
    chk("t2_desc", {57'd0, desc_port, desc_priority}, {57'd0, 4'd2, 3'd3});
    chk("t2_xfer_off", {63'd0, transfering}, 64'd0);
    tick();
    chk("t2_wen_off", {63'd0, sram_wen}, 64'd0);
    chk("t2_wr_count", {48'd0, wr_count}, 64'd1);

    // 3: fill while SRAM stalls, fifth word held off by busy
    do_reset();
    sram_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(12'h100 + 12'(i), 64'h1111_0000_0000_0000 + 64'(i), 3'(i), 4'(i + 4));
      wait_xfer();
    end
    present(12'h1FF, 64'hDEAD_BEEF_0000_0005, 3'd7, 4'd9);
    drain(3);
    chk("t3_busy", {63'd0, busy}, 64'd1);
    chk("t3_no_capture", {63'd0, transfering}, 64'd0);
    chk("t3_captured", 64'(n_xfers), 64'd4);
    chk("t3_no_wen", 64'(n_wens), 64'd0);
    sram_ready = 1'b1;
    wait_xfer();
    request = 1'b0;
    chk("t3_busy_off", {63'd0, busy}, 64'd0);
    drain(8);
    chk("t3_writes", 64'(n_wens), 64'd5);
    chk("t3_left", 64'(exp_q.size()), 64'd0);
    chk("t3_wr_count", {48'd0, wr_count}, 64'd5);

    // 4: request held high on one word
    do_reset();
    sram_ready = 1'b1;
    present(12'h222, 64'h0000_0000_CAFE_F00D, 3'd1, 4'd1);
    drain(10);
    request = 1'b0;
    drain(5);
    chk("t4_xfers", 64'(n_xfers), 64'd5);
    chk("t4_wens", 64'(n_wens), 64'd5);
    chk("t4_wr_count", {48'd0, wr_count}, 64'd5);

    // 5: reset in the middle of a drain
    do_reset();
    sram_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(12'h300 + 12'(i), 64'h5555_0000_0000_0000 + 64'(i), 3'd2, 4'd3);
      wait_xfer();
    end
    request = 1'b0;
    sram_ready = 1'b1;
    tick();
    chk("t5_first_wen", {63'd0, sram_wen}, 64'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("t5_rst_outputs", {60'd0, sram_wen, desc_valid, transfering, busy}, 64'd0);
    chk("t5_rst_count", {48'd0, wr_count}, 64'd0);
    rst = 1'b0;
    n_wens = 0;
    drain(4);
    chk("t5_no_wen", 64'(n_wens), 64'd0);
    present(12'h3AB, 64'h0123_4567_89AB_CDEF, 3'd5, 4'd6);
    wait_xfer();
    request = 1'b0;
    drain(4);
    chk("t5_one_wen", 64'(n_wens), 64'd1);
    chk("t5_wr_count", {48'd0, wr_count}, 64'd1);

    // 6: 2-bit counter saturates
    do_reset();
    sram_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      present(12'h400 + 12'(i), 64'h6666_0000_0000_0000 + 64'(i), 3'd0, 4'd0);
      wait_xfer();
    end
    request = 1'b0;
    drain(6);
    chk("t6_wr_count16", {48'd0, wr_count}, 64'd5);
    chk("t6_wr_count2", {62'd0, wc2}, 64'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
